// File: rtl/handshake_memory_pkg.sv
// Shared constants for the handshake memory: FSM state encoding, transfer
// mode encoding and the legal wait-state range.
package handshake_memory_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAITING = 2'd1;
  localparam logic [1:0] ST_BEAT    = 2'd2;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int WAIT_MAX = 15;
  localparam int WAIT_W   = 4;

  // With zero wait states a beat starts on the very edge that schedules it.
  function automatic logic [1:0] beat_entry_state(input int wait_cycles);
    return (wait_cycles == 0) ? ST_BEAT : ST_WAITING;
  endfunction

endpackage

// File: rtl/memory_array.sv
// 2^M x N storage bank: asynchronous clear, one synchronous write port and
// one combinational read port.
module memory_array #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         WriteEnable,
  input  logic [M-1:0] WriteAddr,
  input  logic [N-1:0] WriteData,
  input  logic [M-1:0] ReadAddr,
  output logic [N-1:0] ReadData
);

  logic [N-1:0] mem_q [2**M];

  // NOTE: every cell is cleared by reset because software relies on reading
  // zero after reset; this rules out mapping the array onto block RAM.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < 2**M; i++) mem_q[i] <= '0;
    end else if (WriteEnable) begin
      mem_q[WriteAddr] <= WriteData;
    end
  end

  assign ReadData = mem_q[ReadAddr];

endmodule

// File: rtl/handshake_memory.sv
// Slow memory model with a Req/Ready handshake, programmable wait states and
// auto-incrementing bursts; outputs are all derived from registered state.
module handshake_memory
  import handshake_memory_pkg::*;
#(
  parameter int N    = 8,
  parameter int M    = 4,
  parameter int WAIT = 2,
  parameter int B    = 2
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         Req,
  input  logic         RW,
  input  logic [M-1:0] Address,
  input  logic [B-1:0] BurstLen,
  input  logic [N-1:0] DataIn,
  output logic [N-1:0] DataOut,
  output logic         Ready,
  output logic         Busy
);

  localparam logic [WAIT_W-1:0] WAIT_INIT   = WAIT_W'(WAIT);
  localparam logic [1:0]        ENTRY_STATE = beat_entry_state(WAIT);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q,  wait_d;
  logic [B-1:0]      beats_q, beats_d;
  logic [M-1:0]      addr_q,  addr_d;
  logic              mode_q,  mode_d;
  logic [N-1:0]      dout_q,  dout_d;
  logic              wr_en;
  logic [N-1:0]      rd_data;

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beats_d = beats_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          addr_d  = Address;
          mode_d  = RW;
          beats_d = BurstLen;
          wait_d  = WAIT_INIT;
          state_d = ENTRY_STATE;
        end
      end
      ST_WAITING: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == WAIT_W'(1)) state_d = ST_BEAT;
      end
      ST_BEAT: begin
        wr_en = (mode_q == MODE_WRITE);
        if (beats_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          beats_d = beats_q - 1'b1;
          addr_d  = addr_q + 1'b1;
          wait_d  = WAIT_INIT;
          state_d = ENTRY_STATE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The read port looks at the address the next beat will use, so DataOut
    // is loaded on the same edge that enters BEAT.
    if (state_d == ST_BEAT && mode_d == MODE_READ) dout_d = rd_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      beats_q <= '0;
      addr_q  <= '0;
      mode_q  <= MODE_READ;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beats_q <= beats_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
    end
  end

  memory_array #(.N(N), .M(M)) u_mem (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .WriteEnable(wr_en),
    .WriteAddr  (addr_q),
    .WriteData  (DataIn),
    .ReadAddr   (addr_d),
    .ReadData   (rd_data)
  );

  assign DataOut = dout_q;
  assign Ready   = (state_q == ST_BEAT);
  assign Busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_handshake_memory.sv
// Directed bench for handshake_memory: a default instance (WAIT=2) and a
// zero-wait-state instance sharing clock and reset.
module tb_handshake_memory;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 0, rw_a = 0, req_b = 0, rw_b = 0;
  logic [3:0] addr_a = 0, addr_b = 0;
  logic [1:0] bl_a = 0, bl_b = 0;
  logic [7:0] din_a = 0, din_b = 0;
  logic [7:0] dout_a, dout_b;
  logic       ready_a, busy_a, ready_b, busy_b;

  int checks = 0;
  int failures = 0;

  // Results of the most recent xfer() call.
  int         x_nb, x_busy;
  bit         x_to;
  int         x_bc [4];
  logic [7:0] x_rd [4];

  always #5 clk = ~clk;

  handshake_memory #(.N(8), .M(4), .WAIT(2), .B(2)) dut_a (
    .Clock(clk), .ResetN(rst_n), .Req(req_a), .RW(rw_a), .Address(addr_a),
    .BurstLen(bl_a), .DataIn(din_a), .DataOut(dout_a), .Ready(ready_a), .Busy(busy_a)
  );

  handshake_memory #(.N(8), .M(4), .WAIT(0), .B(2)) dut_b (
    .Clock(clk), .ResetN(rst_n), .Req(req_b), .RW(rw_b), .Address(addr_b),
    .BurstLen(bl_b), .DataIn(din_b), .DataOut(dout_b), .Ready(ready_b), .Busy(busy_b)
  );

  task automatic drive(input bit sel, input logic req, input logic rw,
                       input logic [3:0] addr, input logic [1:0] bl, input logic [7:0] din);
    if (sel) begin
      req_b = req; rw_b = rw; addr_b = addr; bl_b = bl; din_b = din;
    end else begin
      req_a = req; rw_a = rw; addr_a = addr; bl_a = bl; din_a = din;
    end
  endtask

  // Issues one request from an IDLE cycle and follows it until Busy drops.
  task automatic xfer(input bit sel, input logic rw, input logic [3:0] addr, input logic [1:0] bl,
                      input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3);
    logic [7:0] wd [4];
    logic r, b;
    logic [7:0] d;
    wd[0] = w0; wd[1] = w1; wd[2] = w2; wd[3] = w3;
    x_nb = 0; x_busy = 0; x_to = 1'b1;
    for (int i = 0; i < 4; i++) begin x_bc[i] = -1; x_rd[i] = 8'h00; end
    drive(sel, 1'b1, rw, addr, bl, w0);
    @(posedge clk); #1;
    drive(sel, 1'b0, rw, addr, bl, w0);
    for (int c = 0; c < 64; c++) begin
      if (sel) din_b = wd[(x_nb > 3) ? 3 : x_nb];
      else     din_a = wd[(x_nb > 3) ? 3 : x_nb];
      r = sel ? ready_b : ready_a;
      b = sel ? busy_b  : busy_a;
      d = sel ? dout_b  : dout_a;
      if (!b) begin x_to = 1'b0; break; end
      x_busy++;
      if (r) begin
        if (x_nb < 4) begin x_bc[x_nb] = c; x_rd[x_nb] = d; end
        x_nb++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (x_to) begin failures++; $display("FAIL xfer_timeout: Busy still %0b after 64 cycles, required 0", b); end
  endtask

  task automatic read_expect(input bit sel, input logic [3:0] addr, input logic [7:0] exp, input string name);
    xfer(sel, 1'b0, addr, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    checks++;
    if (x_nb !== 1 || x_rd[0] !== exp) begin
      failures++;
      $display("FAIL %s: addr %0d beats=%0d data=%02h, required beats=1 data=%02h", name, addr, x_nb, x_rd[0], exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, ready_a, dout_a, busy_b, ready_b, dout_b} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs: a busy=%0b ready=%0b dout=%02h b busy=%0b ready=%0b dout=%02h, required all 0",
               busy_a, ready_a, dout_a, busy_b, ready_b, dout_b);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_read_after_reset();
    xfer(1'b0, 1'b0, 4'd5, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    checks++;
    if (x_nb !== 1 || x_bc[0] !== 2) begin
      failures++; $display("FAIL first_read_timing: beats=%0d ready_cycle=%0d, required 1 and 2", x_nb, x_bc[0]);
    end
    checks++;
    if (x_rd[0] !== 8'h00) begin failures++; $display("FAIL first_read_data: got %02h required 00", x_rd[0]); end
    checks++;
    if (x_busy !== 3) begin failures++; $display("FAIL first_read_busy: got %0d cycles required 3", x_busy); end
  endtask

  task automatic test_write_read();
    xfer(1'b0, 1'b1, 4'd9, 2'd0, 8'h3C, 8'h00, 8'h00, 8'h00);
    checks++;
    if (x_nb !== 1 || x_busy !== 3) begin
      failures++; $display("FAIL single_write: beats=%0d busy=%0d, required 1 and 3", x_nb, x_busy);
    end
    read_expect(1'b0, 4'd9,  8'h3C, "read_back_9");
    read_expect(1'b0, 4'd8,  8'h00, "neighbour_8");
    read_expect(1'b0, 4'd10, 8'h00, "neighbour_10");
  endtask

  task automatic test_burst_wrap();
    logic [7:0] exp [4];
    exp[0] = 8'hA1; exp[1] = 8'hA2; exp[2] = 8'hA3; exp[3] = 8'hA4;
    xfer(1'b0, 1'b1, 4'd14, 2'd3, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    checks++;
    if (x_nb !== 4 || x_bc[0] !== 2 || x_bc[1] !== 5 || x_bc[2] !== 8 || x_bc[3] !== 11) begin
      failures++;
      $display("FAIL burst_write_timing: beats=%0d at %0d,%0d,%0d,%0d, required 4 at 2,5,8,11",
               x_nb, x_bc[0], x_bc[1], x_bc[2], x_bc[3]);
    end
    checks++;
    if (x_busy !== 12) begin failures++; $display("FAIL burst_write_busy: got %0d required 12", x_busy); end
    xfer(1'b0, 1'b0, 4'd14, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (x_rd[i] !== exp[i]) begin
        failures++; $display("FAIL burst_read_beat%0d: got %02h required %02h", i, x_rd[i], exp[i]);
      end
    end
    read_expect(1'b0, 4'd0, 8'hA3, "wrap_cell_0");
    read_expect(1'b0, 4'd1, 8'hA4, "wrap_cell_1");
  endtask

  task automatic test_req_ignored();
    int pulses = 0;
    int busy_n = 0;
    bit done = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 4'd3, 2'd0, 8'h00);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 4'd7, 2'd0, 8'hFF);
    for (int c = 0; c < 64; c++) begin
      if (!busy_a) begin
        drive(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 8'h00);
        done = 1'b1;
        break;
      end
      busy_n++;
      if (ready_a) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (!done || pulses !== 1 || busy_n !== 3) begin
      failures++;
      $display("FAIL busy_req_ignored: done=%0b pulses=%0d busy=%0d, required 1, 1 and 3", done, pulses, busy_n);
    end
    read_expect(1'b0, 4'd7, 8'h00, "ignored_write_7");
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    read_expect(1'b0, 4'd9, 8'h3C, "preload_dataout");
    drive(1'b0, 1'b1, 1'b1, 4'd4, 2'd3, 8'h11);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 4'd4, 2'd3, 8'h11);
    for (int c = 0; c < 6; c++) begin
      din_a = (c < 3) ? 8'h11 : 8'h22;
      if (ready_a) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses !== 2 || busy_a !== 1'b1) begin
      failures++; $display("FAIL pre_abort_state: pulses=%0d busy=%0b, required 2 and 1", pulses, busy_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_a !== 1'b0 || ready_a !== 1'b0 || dout_a !== 8'h00) begin
      failures++;
      $display("FAIL async_abort: busy=%0b ready=%0b dout=%02h, required 0 0 00", busy_a, ready_a, dout_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    read_expect(1'b0, 4'd4,  8'h00, "cleared_4");
    read_expect(1'b0, 4'd5,  8'h00, "cleared_5");
    read_expect(1'b0, 4'd9,  8'h00, "cleared_9");
    read_expect(1'b0, 4'd14, 8'h00, "cleared_14");
  endtask

  task automatic test_back_to_back_wait0();
    logic [7:0] exp [4];
    exp[0] = 8'd10; exp[1] = 8'd11; exp[2] = 8'd12; exp[3] = 8'd13;
    xfer(1'b1, 1'b1, 4'd0, 2'd3, 8'd10, 8'd11, 8'd12, 8'd13);
    checks++;
    if (x_nb !== 4 || x_busy !== 4) begin
      failures++; $display("FAIL w0_preload: beats=%0d busy=%0d, required 4 and 4", x_nb, x_busy);
    end
    xfer(1'b1, 1'b0, 4'd0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00);
    checks++;
    if (x_nb !== 4 || x_busy !== 4 || x_bc[0] !== 0 || x_bc[1] !== 1 || x_bc[2] !== 2 || x_bc[3] !== 3) begin
      failures++;
      $display("FAIL w0_ready_run: beats=%0d busy=%0d at %0d,%0d,%0d,%0d, required 4 4 at 0,1,2,3",
               x_nb, x_busy, x_bc[0], x_bc[1], x_bc[2], x_bc[3]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (x_rd[i] !== exp[i]) begin
        failures++; $display("FAIL w0_read_beat%0d: got %0d required %0d", i, x_rd[i], exp[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_burst_wrap();
    test_req_ignored();
    test_reset_mid();
    test_back_to_back_wait0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/handshake_memory.md
# handshake_memory

Parametrised successor to the single-cycle register memory: a 2^M × N-bit storage bank with a request/ready handshake, configurable wait states and auto-incrementing bursts. It separates the data-in and data-out buses, so no tri-state bus is needed. It sits between the machine's control unit and storage, modelling slow memory that the sequencer must poll via `Ready`/`Busy`.

## Interface
- `N`, default 8: cell width in bits.
- `M`, default 4: address width; cell count is 2^M.
- `WAIT`, default 2: wait cycles before each beat; legal range 0..15.
- `B`, default 2: burst-length field width; a burst carries up to 2^B beats.
- `Clock`, input, 1: single clock; all state changes on posedge.
- `ResetN`, input, 1: asynchronous, active-low reset.
- `Req`, input, 1: transfer request; sampled only in IDLE.
- `RW`, input, 1: 0 = read, 1 = write; latched with `Req`.
- `Address`, input, M: start address; latched with `Req`.
- `BurstLen`, input, B: beat count minus 1; latched with `Req`.
- `DataIn`, input, N: write data; sampled at the edge that ends a write beat.
- `DataOut`, output, N: registered read data.
- `Ready`, output, 1: one-cycle pulse marking each beat.
- `Busy`, output, 1: high while a transfer is in progress.

## Operation
- FSM states:
  - IDLE: `Busy`=0, `Ready`=0.
  - WAITING: `Busy`=1, `Ready`=0.
  - BEAT: `Busy`=1, `Ready`=1.
- IDLE transitions: on an edge with `Req`=1, latch `Address`→addr, `RW`→mode and `BurstLen`→beats_left. Go to WAITING with wait counter = `WAIT`; if `WAIT`=0, go directly to BEAT.
- WAITING: decrement the counter each edge. Move to BEAT on the edge where the counter reaches 0 (exactly `WAIT` cycles spent in WAITING).
- Read data: on every edge that enters BEAT in read mode, `DataOut` ← cell[addr]. `DataOut` holds that value until the next read beat and is unchanged by writes.
- BEAT, on the edge that ends the cycle:
  - Write mode: cell[addr] ← `DataIn`.
  - If beats_left=0, go to IDLE.
  - Otherwise decrement beats_left, set addr ← addr+1 modulo 2^M (wraps 2^M−1 → 0), reload the wait counter and go to WAITING, or to BEAT again if `WAIT`=0.
- `Req` is ignored whenever `Busy`=1. No queuing and no error flag.
- A read issued after a write completes returns the written data; the write commits before IDLE is re-entered.
- Reset (`ResetN`=0, asynchronous): every cell = 0, FSM = IDLE, `DataOut` = 0, `Ready` = 0, `Busy` = 0, all latched fields = 0.
  - Reset mid-transfer aborts the transfer immediately. The beat in progress does not write.
  - Operation resumes on the first posedge after `ResetN` rises.

## Timing
- Let E0 be the edge that samples `Req`=1 in IDLE. Beat k (k = 0..BurstLen) has `Ready` high in the cycle following edge E0 + k·(`WAIT`+1) + `WAIT`.
- `Busy` rises after E0 and stays high for (`BurstLen`+1)·(`WAIT`+1) cycles.
- `WAIT`=0: `Ready` is high for `BurstLen`+1 consecutive cycles.
- Minimum turnaround is one IDLE cycle between the last `Ready` and the next `Req` sample.
- `DataIn` must be stable around the edge ending each write beat. It is not sampled at any other time.
- `Ready`, `Busy` and `DataOut` are all registered outputs (or decoded from registered state). No combinational path runs from inputs to outputs.

## Structure
- A shared package holds:
  - state encoding constants: IDLE=0, WAITING=1, BEAT=2;
  - mode constants: READ=0, WRITE=1;
  - the `WAIT` range limit.
- Sub-module `memory_array`: 2^M × N cells with asynchronous clear on `ResetN`, one synchronous write port (`WriteEnable`, address, data) and one combinational read port.
- The top level contains the FSM, wait counter, beat counter, address incrementer and the `DataOut` register.

## Test plan
- Defaults (N=8, M=4, WAIT=2, B=2), after reset: read addr 5 with BurstLen=0. Expect `Ready` pulse after edge E0+2 with `DataOut`=0x00, and `Busy` high for 3 cycles.
- Write 0x3C to addr 9, then read addr 9. Expect `DataOut`=0x3C; addr 8 and addr 10 still read 0x00.
- Write burst at addr 14, BurstLen=3, data A1/A2/A3/A4. Expect cells 14, 15, 0, 1 to hold these values, and `Ready` pulses spaced 3 cycles apart. A read burst at addr 14 returns A1..A4 in order (wrap verified).
- During a busy read of addr 3, assert `Req` with RW=1, addr 7, `DataIn`=0xFF. Expect it ignored: only one `Ready` pulse and addr 7 stays 0x00.
- Drop `ResetN` one cycle after the 2nd beat of a 4-beat write burst. Expect `Busy`, `Ready` and `DataOut` to go to 0 immediately, and all cells to read 0x00 afterward.
- WAIT=0 instance: preload cells 0..3 = 10, 11, 12, 13, then read burst at addr 0 with BurstLen=3. Expect `Ready` high for 4 consecutive cycles with `DataOut` = 10, 11, 12, 13.
